// File: rtl/joystick_spi_reader.sv
// SPI mode-0 master that polls a PmodJSTK-style joystick at a fixed rate and
// publishes the 10-bit X/Y positions and the three button bits atomically.
module joystick_spi_reader #(
    parameter int SCLK_DIV    = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 3333333
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] buttons,
    output logic       sample_valid,
    output logic       busy
);

    localparam int TMR_SPAN = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int TMR_TOP  = (TMR_SPAN > 2 * SCLK_DIV) ? TMR_SPAN : 2 * SCLK_DIV;
    localparam int TMR_W    = $clog2(TMR_TOP + 1);
    localparam int POLL_W   = $clog2(POLL_PERIOD + 1);

    localparam logic [TMR_W-1:0]  SETUP_END = TMR_W'(SS_SETUP - 1);
    localparam logic [TMR_W-1:0]  GAP_END   = TMR_W'(BYTE_GAP - 1);
    localparam logic [TMR_W-1:0]  SAMPLE_PT = TMR_W'(SCLK_DIV - 1);
    localparam logic [TMR_W-1:0]  SCLK_HIGH = TMR_W'(SCLK_DIV);
    localparam logic [TMR_W-1:0]  BIT_END   = TMR_W'(2 * SCLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_END  = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
    logic [POLL_W-1:0]   poll_cnt_r, poll_nxt_s;
    logic [2:0]          bit_idx_r, bit_nxt_s;
    logic [2:0]          byte_idx_r, byte_nxt_s;

    logic                ss_n_r, sclk_r, mosi_r, busy_r, sv_r;
    logic                ss_n_nxt_s, sclk_nxt_s, mosi_nxt_s, busy_nxt_s, sv_nxt_s;

    logic [1:0]          led_r;
    logic [7:0]          shift_r;
    logic [7:0]          x_lo_r, y_lo_r;
    logic [1:0]          x_hi_r, y_hi_r;
    logic [9:0]          joy_x_r, joy_y_r;
    logic [2:0]          buttons_r;

    // Command stream: only byte 0 carries data, the other four are zero.
    function automatic logic tx_bit(input logic [2:0] byte_i,
                                    input logic [2:0] bit_i,
                                    input logic [1:0] led_i);
        logic [7:0] tx_byte;
        tx_byte = (byte_i == 3'd0) ? {6'b100000, led_i} : 8'h00;
        return tx_byte[bit_i];
    endfunction

    // Next-state, timer/index bookkeeping and next values of the pin registers.
    always_comb begin
        state_nxt_s = state_r;
        tmr_nxt_s   = tmr_r;
        poll_nxt_s  = poll_cnt_r;
        bit_nxt_s   = bit_idx_r;
        byte_nxt_s  = byte_idx_r;

        case (state_r)
            ST_IDLE: begin
                if (poll_cnt_r == POLL_END) begin
                    if (enable) begin
                        state_nxt_s = ST_SETUP;
                        poll_nxt_s  = '0;
                        tmr_nxt_s   = '0;
                    end else begin
                        poll_nxt_s  = poll_cnt_r;
                    end
                end else begin
                    poll_nxt_s = poll_cnt_r + POLL_W'(1);
                end
            end
            ST_SETUP: begin
                if (tmr_r == SETUP_END) begin
                    state_nxt_s = ST_SHIFT;
                    tmr_nxt_s   = '0;
                    bit_nxt_s   = 3'd7;
                    byte_nxt_s  = 3'd0;
                end else begin
                    tmr_nxt_s = tmr_r + TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (tmr_r == BIT_END) begin
                    tmr_nxt_s = '0;
                    if (bit_idx_r == 3'd0) begin
                        bit_nxt_s = 3'd7;
                        if (byte_idx_r == 3'd4) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_GAP;
                            byte_nxt_s  = byte_idx_r + 3'd1;
                        end
                    end else begin
                        bit_nxt_s = bit_idx_r - 3'd1;
                    end
                end else begin
                    tmr_nxt_s = tmr_r + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_r == GAP_END) begin
                    state_nxt_s = ST_SHIFT;
                    tmr_nxt_s   = '0;
                end else begin
                    tmr_nxt_s = tmr_r + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                poll_nxt_s  = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                poll_nxt_s  = '0;
            end
        endcase

        ss_n_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
        sclk_nxt_s = 1'b0;
        mosi_nxt_s = 1'b0;
        sv_nxt_s   = 1'b0;

        case (state_nxt_s)
            ST_SETUP: begin
                ss_n_nxt_s = 1'b0;
                busy_nxt_s = 1'b1;
                mosi_nxt_s = tx_bit(3'd0, 3'd7, led_r);
            end
            ST_SHIFT: begin
                ss_n_nxt_s = 1'b0;
                busy_nxt_s = 1'b1;
                sclk_nxt_s = (tmr_nxt_s >= SCLK_HIGH);
                mosi_nxt_s = tx_bit(byte_nxt_s, bit_nxt_s, led_r);
            end
            ST_GAP: begin
                ss_n_nxt_s = 1'b0;
                busy_nxt_s = 1'b1;
                mosi_nxt_s = tx_bit(byte_nxt_s, 3'd7, led_r);
            end
            ST_DONE: begin
                sv_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                sv_nxt_s = 1'b0;
            end
            default: begin
                sv_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, shared timer, bit/byte indices and poll counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            tmr_r      <= '0;
            poll_cnt_r <= '0;
            bit_idx_r  <= 3'd7;
            byte_idx_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            tmr_r      <= tmr_nxt_s;
            poll_cnt_r <= poll_nxt_s;
            bit_idx_r  <= bit_nxt_s;
            byte_idx_r <= byte_nxt_s;
        end
    end

    // Registered SPI pins and status flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            ss_n_r <= 1'b1;
            sclk_r <= 1'b0;
            mosi_r <= 1'b0;
            busy_r <= 1'b0;
            sv_r   <= 1'b0;
        end else begin
            ss_n_r <= ss_n_nxt_s;
            sclk_r <= sclk_nxt_s;
            mosi_r <= mosi_nxt_s;
            busy_r <= busy_nxt_s;
            sv_r   <= sv_nxt_s;
        end
    end

    // Receive path: sample miso as sclk rises, keep only the bits that matter,
    // and publish everything on the single edge that enters DONE.
    always_ff @(posedge clk) begin
        if (clr) begin
            led_r     <= 2'b00;
            shift_r   <= 8'h00;
            x_lo_r    <= 8'h00;
            y_lo_r    <= 8'h00;
            x_hi_r    <= 2'b00;
            y_hi_r    <= 2'b00;
            joy_x_r   <= 10'd512;
            joy_y_r   <= 10'd512;
            buttons_r <= 3'b000;
        end else begin
            if (state_r == ST_IDLE && state_nxt_s == ST_SETUP) begin
                led_r <= led;
            end
            if (state_r == ST_SHIFT && tmr_r == SAMPLE_PT) begin
                shift_r <= {shift_r[6:0], miso};
            end
            if (state_r == ST_SHIFT && tmr_r == BIT_END && bit_idx_r == 3'd0) begin
                case (byte_idx_r)
                    3'd0:    x_lo_r <= shift_r;
                    3'd1:    x_hi_r <= shift_r[1:0];
                    3'd2:    y_lo_r <= shift_r;
                    3'd3:    y_hi_r <= shift_r[1:0];
                    default: x_lo_r <= x_lo_r;
                endcase
            end
            if (state_nxt_s == ST_DONE) begin
                joy_x_r   <= {x_hi_r, x_lo_r};
                joy_y_r   <= {y_hi_r, y_lo_r};
                buttons_r <= shift_r[2:0];
            end
        end
    end

    assign ss_n         = ss_n_r;
    assign sclk         = sclk_r;
    assign mosi         = mosi_r;
    assign busy         = busy_r;
    assign sample_valid = sv_r;
    assign joy_x        = joy_x_r;
    assign joy_y        = joy_y_r;
    assign buttons      = buttons_r;

endmodule
